zap_wb_ram_responder: RTL

Wishbone B3 responder (slave) fronting an on-chip word-addressed SRAM. It is the far end of the bus driven by the cache/MMU/TLB initiator complex. It serves classic single cycles and CTI incrementing bursts (linear and wrap) with programmable initial wait states, and keeps ACK asserted every cycle during a burst. It is used as boot/scratch memory and as the bench memory model for the cache subsystem.

---
 rtl/zap_wb_pkg.sv | 32 +++
 rtl/zap_wb_ram_responder_if.sv | 26 ++
 rtl/zap_wb_resp_mem.sv | 49 ++++
 rtl/zap_wb_ram_responder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/zap_wb_pkg.sv
// Shared Wishbone definitions for the RAM responder: cycle-type codes,
// burst-type enum, responder FSM states and the wrap-burst address mask.
package zap_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_BURST = 2'b10
    } resp_state_t;

    // Low word-index bits that roll over inside a wrapping burst block.
    function automatic logic [3:0] wrap_mask(input bte_t bte);
        case (bte)
            BTE_WRAP4:  return 4'h3;
            BTE_WRAP8:  return 4'h7;
            BTE_WRAP16: return 4'hF;
            default:    return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/zap_wb_ram_responder_if.sv
// Wishbone B3 bus bundle between the initiator complex and the RAM responder.
// Fields map onto the bus as: cyc/stb/wen/sel/adr/wdat/cti/bte (initiator to
// responder) and rdat/ack/err (responder to initiator).
interface zap_wb_ram_responder_if;
    logic        cyc;
    logic        stb;
    logic        wen;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, wen, sel, adr, wdat, cti, bte,
        input  rdat, ack, err
    );

    modport slave (
        input  cyc, stb, wen, sel, adr, wdat, cti, bte,
        output rdat, ack, err
    );
endinterface

// File: rtl/zap_wb_resp_mem.sv
// DEPTH x 32 byte-enabled SRAM with one write port and one registered read
// port. A read of the word being written at the same edge returns the new
// bytes (write-first bypass). The read register clears on reset or rd_clr.
// Ports: clk, rst_n, wr_en/wr_be/wr_idx/wr_dat, rd_en/rd_clr/rd_idx, rd_dat.
module zap_wb_resp_mem #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [3:0]               wr_be,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [31:0]              wr_dat,
    input  logic                     rd_en,
    input  logic                     rd_clr,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [31:0]              rd_dat
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_dat_q, rd_dat_d;
    logic [31:0] rd_byp;

    // Byte-enabled write; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

    // Read data with same-edge write bypass.
    always_comb begin
        rd_byp   = mem_q[rd_idx];
        rd_dat_d = rd_dat_q;
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b] && (wr_idx == rd_idx)) rd_byp[8*b +: 8] = wr_dat[8*b +: 8];
        end
        if (rd_clr)     rd_dat_d = '0;
        else if (rd_en) rd_dat_d = rd_byp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_dat_q <= '0;
        else        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;
endmodule

// File: rtl/zap_wb_ram_responder.sv
// Wishbone B3 responder fronting an on-chip word-addressed SRAM. Serves
// classic cycles and incrementing bursts (linear, wrap4/8/16) with
// WAIT_STATES initial wait cycles and back-to-back acks within a burst.
// Ports: i_clk, i_reset_n (async, active low), wb (slave side of the bus).
// Optional build macro ZAP_WB_RESP_ERR_EN: out-of-range accesses answer with
// err instead of ack; when undefined the index aliases modulo DEPTH.
module zap_wb_ram_responder
    import zap_wb_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    zap_wb_ram_responder_if.slave  wb
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam bit          HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [3:0]  WS_LOAD  = 4'((WAIT_STATES == 0) ? 32'd0 : WAIT_STATES - 32'd1);

    resp_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [31:0]   off;
    logic [31:0]   cur_full, inc_full, nxt_full, wmask;
    logic [AW-1:0] cur_idx, nxt_idx, rd_idx;
    logic          cur_ok, nxt_ok;
    logic          rd_en, rd_clr, wr_en;
    bte_t          bte;

    // Word index of the current beat and of the following burst beat.
    assign bte      = bte_t'(wb.bte);
    assign off      = wb.adr - BASE_ADDR;
    assign cur_full = {2'b00, off[31:2]};
    assign inc_full = cur_full + 32'd1;
    assign wmask    = {28'd0, wrap_mask(bte)};
    assign nxt_full = (bte == BTE_LINEAR) ? inc_full
                                          : ((cur_full & ~wmask) | (inc_full & wmask));
    assign cur_idx  = cur_full[AW-1:0];
    assign nxt_idx  = nxt_full[AW-1:0];

`ifdef ZAP_WB_RESP_ERR_EN
    assign cur_ok = (cur_full < DEPTH);
    assign nxt_ok = (nxt_full < DEPTH);
`else
    assign cur_ok = 1'b1;
    assign nxt_ok = 1'b1;
    logic unused_range;
    assign unused_range = ^{cur_full[31:AW], nxt_full[31:AW]};
`endif

    logic unused_off;
    assign unused_off = ^off[1:0];

    // A write commits only on an acknowledged beat.
    assign wr_en = wb.cyc && wb.stb && ack_q && wb.wen;

    // Next-state and beat response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        rd_clr  = 1'b0;
        rd_idx  = cur_idx;
        unique case (state_q)
            ST_IDLE: begin
                if (wb.cyc && wb.stb) begin
                    if (HAS_WAIT) begin
                        cnt_d   = WS_LOAD;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_BURST;
                        ack_d   = cur_ok;
                        err_d   = !cur_ok;
                        rd_en   = cur_ok;
                        rd_clr  = !cur_ok;
                    end
                end
            end
            ST_WAIT: begin
                if (!(wb.cyc && wb.stb)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_BURST;
                    ack_d   = cur_ok;
                    err_d   = !cur_ok;
                    rd_en   = cur_ok;
                    rd_clr  = !cur_ok;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_BURST: begin
                // Any beat other than an acked incrementing one ends the access;
                // an err beat, a stall or a dropped cyc all land here too.
                state_d = ST_IDLE;
                if (wb.cyc && wb.stb && ack_q && (wb.cti == CTI_INCR)) begin
                    state_d = ST_BURST;
                    rd_idx  = nxt_idx;
                    ack_d   = nxt_ok;
                    err_d   = !nxt_ok;
                    rd_en   = nxt_ok;
                    rd_clr  = !nxt_ok;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    zap_wb_resp_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .wr_en  (wr_en),
        .wr_be  (wb.sel),
        .wr_idx (cur_idx),
        .wr_dat (wb.wdat),
        .rd_en  (rd_en),
        .rd_clr (rd_clr),
        .rd_idx (rd_idx),
        .rd_dat (wb.rdat)
    );

    assign wb.ack = ack_q;
    assign wb.err = err_q;
endmodule
